// File: rtl/mouse_master_sm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mouse_master_sm_if                                              |
// | Brief    : Byte-level transmit/receive and packet-publish bundle.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface mouse_master_sm_if;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic [7:0] MOUSE_STATUS;
    logic [7:0] MOUSE_DX;
    logic [7:0] MOUSE_DY;
    logic       SEND_INTERRUPT;

    modport master (
        output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        output MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
        input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );

    modport slave (
        input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        input  MOUSE_STATUS, MOUSE_DX, MOUSE_DY, SEND_INTERRUPT,
        output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );
endinterface
`default_nettype wire

// File: rtl/mouse_master_sm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mouse_master_sm                                                 |
// | Brief    : PS/2 mouse host FSM: reset/enable handshake, 3-byte stream.      |
// |            Option MOUSE_SM_SYNC_CHECK_EN: drop status bytes with bit3=0.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mouse_master_sm #(
    parameter int unsigned POWERUP_CYCLES = 5000,
    parameter int unsigned RESP_TIMEOUT   = 5000000
) (
    input  logic              CLK,
    input  logic              RESET,
    mouse_master_sm_if.master bus
);

    localparam logic [31:0] C_POWERUP = 32'(POWERUP_CYCLES);
    localparam logic [31:0] C_TIMEOUT = 32'(RESP_TIMEOUT);
    localparam logic [7:0]  C_CMD_RST = 8'hFF;
    localparam logic [7:0]  C_CMD_EN  = 8'hF4;

    typedef enum logic [3:0] {
        INIT_WAIT     = 4'd0,
        SEND_RST      = 4'd1,
        WAIT_RST_SENT = 4'd2,
        WAIT_ACK1     = 4'd3,
        WAIT_SELFTEST = 4'd4,
        WAIT_ID       = 4'd5,
        SEND_EN       = 4'd6,
        WAIT_EN_SENT  = 4'd7,
        WAIT_ACK2     = 4'd8,
        RD_B1         = 4'd9,
        RD_B2         = 4'd10,
        RD_B3         = 4'd11,
        PUBLISH       = 4'd12
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  sh1_q, sh1_d, sh2_q, sh2_d, sh3_q, sh3_d;
    logic [7:0]  status_q, status_d, dx_q, dx_d, dy_q, dy_d;
    logic        irq_q, irq_d;
    logic        rx_good, rx_bad, timed_out, b1_sync_ok;

    assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    assign timed_out = (cnt_inc >= C_TIMEOUT);
    assign rx_good   = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == 2'b00);
    assign rx_bad    = bus.BYTE_READY && (bus.BYTE_ERROR_CODE != 2'b00);

`ifdef MOUSE_SM_SYNC_CHECK_EN
    assign b1_sync_ok = bus.BYTE_READ[3];
`else
    assign b1_sync_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        sh3_d    = sh3_q;
        status_d = status_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        irq_d    = 1'b0;

        case (state_q)
            INIT_WAIT: if (cnt_q >= C_POWERUP) state_d = SEND_RST;
            SEND_RST:  state_d = WAIT_RST_SENT;
            SEND_EN:   state_d = WAIT_EN_SENT;
            WAIT_RST_SENT: begin
                if (bus.BYTE_SENT)  state_d = WAIT_ACK1;
                else if (timed_out) state_d = INIT_WAIT;
            end
            WAIT_EN_SENT: begin
                if (bus.BYTE_SENT)  state_d = WAIT_ACK2;
                else if (timed_out) state_d = INIT_WAIT;
            end
            // Any unexpected or corrupted handshake byte restarts from power-up.
            WAIT_ACK1: begin
                if (bus.BYTE_READY)
                    state_d = (rx_good && bus.BYTE_READ == 8'hFA) ? WAIT_SELFTEST : INIT_WAIT;
                else if (timed_out) state_d = INIT_WAIT;
            end
            WAIT_SELFTEST: begin
                if (bus.BYTE_READY)
                    state_d = (rx_good && bus.BYTE_READ == 8'hAA) ? WAIT_ID : INIT_WAIT;
                else if (timed_out) state_d = INIT_WAIT;
            end
            WAIT_ID: begin
                if (bus.BYTE_READY)
                    state_d = (rx_good && bus.BYTE_READ == 8'h00) ? SEND_EN : INIT_WAIT;
                else if (timed_out) state_d = INIT_WAIT;
            end
            WAIT_ACK2: begin
                if (bus.BYTE_READY)
                    state_d = (rx_good && bus.BYTE_READ == 8'hFA) ? RD_B1 : INIT_WAIT;
                else if (timed_out) state_d = INIT_WAIT;
            end
            RD_B1: begin
                if (rx_good && b1_sync_ok) begin
                    sh1_d   = bus.BYTE_READ;
                    state_d = RD_B2;
                end
            end
            RD_B2: begin
                if (rx_good) begin
                    sh2_d   = bus.BYTE_READ;
                    state_d = RD_B3;
                end else if (rx_bad || timed_out) begin
                    state_d = RD_B1;
                end
            end
            RD_B3: begin
                if (rx_good) begin
                    sh3_d   = bus.BYTE_READ;
                    state_d = PUBLISH;
                end else if (rx_bad || timed_out) begin
                    state_d = RD_B1;
                end
            end
            PUBLISH: begin
                status_d = sh1_q;
                dx_d     = sh2_q;
                dy_d     = sh3_q;
                irq_d    = 1'b1;
                state_d  = RD_B1;
            end
            default: state_d = INIT_WAIT;
        endcase

        // A corrupted stream byte throws away the partial packet.
        if ((state_q inside {RD_B1, RD_B2, RD_B3}) && rx_bad) begin
            sh1_d = 8'h00;
            sh2_d = 8'h00;
            sh3_d = 8'h00;
        end
    end

    assign cnt_d = (state_d != state_q) ? 32'd0 : cnt_inc;
    assign cmd_d = (state_d == SEND_RST) ? C_CMD_RST :
                   (state_d == SEND_EN)  ? C_CMD_EN  : cmd_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= INIT_WAIT;
            cnt_q    <= 32'd0;
            cmd_q    <= 8'h00;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
            sh3_q    <= 8'h00;
            status_q <= 8'h00;
            dx_q     <= 8'h00;
            dy_q     <= 8'h00;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_q    <= cmd_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            sh3_q    <= sh3_d;
            status_q <= status_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            irq_q    <= irq_d;
        end
    end

    assign bus.SEND_BYTE      = (state_q == SEND_RST) || (state_q == SEND_EN);
    assign bus.BYTE_TO_SEND   = cmd_q;
    assign bus.READ_ENABLE    = state_q inside {WAIT_ACK1, WAIT_SELFTEST, WAIT_ID, WAIT_ACK2,
                                                RD_B1, RD_B2, RD_B3, PUBLISH};
    assign bus.MOUSE_STATUS   = status_q;
    assign bus.MOUSE_DX       = dx_q;
    assign bus.MOUSE_DY       = dy_q;
    assign bus.SEND_INTERRUPT = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_master_sm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mouse_master_sm                                              |
// | Brief    : Directed + random bench for mouse_master_sm with packet model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mouse_master_sm;

    localparam int unsigned P_PWR = 10;
    localparam int unsigned P_TO  = 100;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    mouse_master_sm_if bus();

    mouse_master_sm #(.POWERUP_CYCLES(P_PWR), .RESP_TIMEOUT(P_TO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] pkt[$];
    logic [7:0] exp_st = 8'h00, exp_dx = 8'h00, exp_dy = 8'h00;
    logic       exp_irq = 1'b0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Packet model: good bytes accumulate, any bad byte drops the partial packet.
    function automatic void model_rx(input logic [7:0] b, input logic [1:0] e);
        exp_irq = 1'b0;
        if (e != 2'b00) begin
            pkt.delete();
            return;
        end
`ifdef MOUSE_SM_SYNC_CHECK_EN
        if (pkt.size() == 0 && !b[3]) return;
`endif
        pkt.push_back(b);
        if (pkt.size() == 3) begin
            exp_st  = pkt[0];
            exp_dx  = pkt[1];
            exp_dy  = pkt[2];
            exp_irq = 1'b1;
            pkt.delete();
        end
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_send"}, 32'(bus.SEND_BYTE), 32'd0);
        chk({tag, "_cmd"},  32'(bus.BYTE_TO_SEND), 32'h00);
        chk({tag, "_ren"},  32'(bus.READ_ENABLE), 32'd0);
        chk({tag, "_st"},   32'(bus.MOUSE_STATUS), 32'h00);
        chk({tag, "_dx"},   32'(bus.MOUSE_DX), 32'h00);
        chk({tag, "_dy"},   32'(bus.MOUSE_DY), 32'h00);
        chk({tag, "_irq"},  32'(bus.SEND_INTERRUPT), 32'd0);
    endtask

    task automatic wait_send(input string tag, input int exp_n, input logic [7:0] exp_b);
        int n = 0;
        while (bus.SEND_BYTE !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_n));
        chk({tag, "_cmd"}, 32'(bus.BYTE_TO_SEND), 32'(exp_b));
        chk({tag, "_ren"}, 32'(bus.READ_ENABLE), 32'd0);
        tick();
        chk({tag, "_pulse"}, 32'(bus.SEND_BYTE), 32'd0);
    endtask

    task automatic byte_sent(input string tag, input logic [7:0] exp_b);
        repeat ($urandom_range(0, 3)) tick();
        chk({tag, "_hold"}, 32'(bus.BYTE_TO_SEND), 32'(exp_b));
        bus.BYTE_SENT = 1'b1;
        tick();
        bus.BYTE_SENT = 1'b0;
        chk({tag, "_ren"}, 32'(bus.READ_ENABLE), 32'd1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic [1:0] e);
        bus.BYTE_READ       = b;
        bus.BYTE_ERROR_CODE = e;
        bus.BYTE_READY      = 1'b1;
        tick();
        bus.BYTE_READY      = 1'b0;
        bus.BYTE_ERROR_CODE = 2'b00;
    endtask

    task automatic init_feed(input logic [7:0] b, input logic [1:0] e);
        repeat ($urandom_range(0, 3)) tick();
        drive_rx(b, e);
    endtask

    task automatic stream(input logic [7:0] b, input logic [1:0] e);
        drive_rx(b, e);
        model_rx(b, e);
        chk("irq_early", 32'(bus.SEND_INTERRUPT), 32'd0);
        tick();
        chk("irq",    32'(bus.SEND_INTERRUPT), 32'(exp_irq));
        chk("status", 32'(bus.MOUSE_STATUS), 32'(exp_st));
        chk("dx",     32'(bus.MOUSE_DX), 32'(exp_dx));
        chk("dy",     32'(bus.MOUSE_DY), 32'(exp_dy));
        if (exp_irq) begin
            tick();
            chk("irq_pulse", 32'(bus.SEND_INTERRUPT), 32'd0);
        end
        repeat ($urandom_range(0, 2)) tick();
    endtask

    initial begin
        logic [7:0] rb;
        logic [1:0] re;
        int         n;

        bus.BYTE_SENT       = 1'b0;
        bus.BYTE_READ       = 8'h00;
        bus.BYTE_ERROR_CODE = 2'b00;
        bus.BYTE_READY      = 1'b0;
        repeat (3) tick();
        chk_reset_vals("rst");

        // Power-up and reset command; a stray received byte before BYTE_SENT is ignored
        RESET = 1'b1;
        wait_send("pwr", P_PWR + 1, 8'hFF);
        drive_rx(8'h12, 2'b11);
        byte_sent("rst_sent", 8'hFF);
        init_feed(8'hFA, 2'b00);
        init_feed(8'hAA, 2'b00);
        init_feed(8'h00, 2'b00);
        wait_send("en", 0, 8'hF4);
        byte_sent("en_sent", 8'hF4);
        init_feed(8'hFA, 2'b00);
        chk("stream_ren", 32'(bus.READ_ENABLE), 32'd1);

        // BYTE_SENT outside a send-wait state has no effect
        bus.BYTE_SENT = 1'b1;
        tick();
        bus.BYTE_SENT = 1'b0;
        chk("stray_sent_ren", 32'(bus.READ_ENABLE), 32'd1);
        chk("stray_sent_send", 32'(bus.SEND_BYTE), 32'd0);

        // Status without sync bit, then the canonical packet
        stream(8'h01, 2'b00);
        stream(8'h22, 2'b00);
        stream(8'h33, 2'b00);
        stream(8'h09, 2'b00);
        stream(8'h05, 2'b00);
        stream(8'hFB, 2'b00);

        // Byte 2 corrupted, next three good bytes form a packet
        stream(8'h18, 2'b00);
        stream(8'h44, 2'b01);
        stream(8'h2C, 2'b00);
        stream(8'h7E, 2'b00);
        stream(8'h80, 2'b00);

        for (int i = 0; i < 40; i++) begin
            rb = 8'($urandom);
            re = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            stream(rb, re);
        end

        // Mid-packet silence times out back to byte 1
        stream(8'h00, 2'b10);
        stream(8'h08, 2'b00);
        repeat (P_TO + 5) tick();
        pkt.delete();
        stream(8'h1A, 2'b00);
        stream(8'h02, 2'b00);
        stream(8'h03, 2'b00);

        // Asynchronous reset in the middle of a packet
        stream(8'h0F, 2'b00);
        #3;
        RESET = 1'b0;
        #1;
        chk_reset_vals("midrst");
        pkt.delete();
        exp_st = 8'h00;
        exp_dx = 8'h00;
        exp_dy = 8'h00;
        tick();
        RESET = 1'b1;
        wait_send("pwr2", P_PWR + 1, 8'hFF);
        byte_sent("rst2_sent", 8'hFF);
        init_feed(8'hFA, 2'b00);
        init_feed(8'hFC, 2'b00);
        chk("selftest_fail_ren", 32'(bus.READ_ENABLE), 32'd0);
        wait_send("restart", P_PWR + 1, 8'hFF);
        byte_sent("rst3_sent", 8'hFF);

        // No answer after the reset command
        n = 0;
        while (bus.READ_ENABLE === 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        chk("ack_timeout", 32'(n), 32'(P_TO));
        wait_send("to_restart", P_PWR + 1, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
